// File: rtl/uart_rx_pro_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_pro_if
//  Purpose  : Receive-side word handshake between uart_rx_pro and its
//             consumer: data/flags held under valid until ready accepts.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_pro_if #(
    parameter int WORD_SIZE = 8
) ();
    logic [WORD_SIZE-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic                 rx_busy;

    // Receiver side: produces the word and its status.
    modport master (
        output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy,
        input  rx_ready
    );

    // Consumer side: accepts words.
    modport slave (
        input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_pro.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_pro
//  Purpose  : Oversampling UART receiver with mid-bit sampling, false-start
//             rejection, parity/framing/overrun detection and a held
//             valid/ready output.
//  Option   : define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_pro #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int WORD_SIZE  = 8,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     rx,
    uart_rx_pro_if.master bus
);
    localparam int c_DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
    localparam int c_PW      = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_SW      = $clog2(OVERSAMPLE);
    localparam int c_BW      = $clog2(WORD_SIZE);
    localparam int c_MID     = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
    // Decisions wait one tick past mid-bit so the third vote is available.
    localparam int c_DEC     = c_MID + 1;
`else
    localparam int c_DEC     = c_MID;
`endif
    localparam logic [c_SW-1:0] c_SC_DEC  = c_SW'(c_DEC);
    localparam logic [c_SW-1:0] c_SC_LAST = c_SW'(OVERSAMPLE - 1);
    localparam logic [c_PW-1:0] c_PS_LAST = c_PW'(c_DIV - 1);
    localparam logic [c_BW-1:0] c_BC_LAST = c_BW'(WORD_SIZE - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_PAR   = 3'd3;
    localparam logic [2:0] c_STOP  = 3'd4;

    logic [1:0]           r_sync;
    logic [c_PW-1:0]      r_presc;
    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [c_SW-1:0]      r_sc;
    logic [c_BW-1:0]      r_bc;
    logic                 r_stc;
    logic [WORD_SIZE-1:0] r_word;
    logic                 r_perr_acc;
    logic                 r_ferr_acc;
    logic [WORD_SIZE-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_ovr;

    logic                 w_rxs;
    logic                 w_tick;
    logic                 w_bit;
    logic                 w_at_dec;
    logic                 w_at_last;
    logic                 w_last_bit;
    logic                 w_last_stop;
    logic                 w_busy;
    logic                 w_complete;
    logic [c_BW-1:0]      w_idx;

    assign w_rxs       = r_sync[1];
    assign w_tick      = (r_presc == c_PS_LAST);
    assign w_at_dec    = w_tick && (r_sc == c_SC_DEC);
    assign w_at_last   = w_tick && (r_sc == c_SC_LAST);
    assign w_last_bit  = (r_bc == c_BW'(WORD_SIZE - 1));
    assign w_last_stop = (STOP_BITS == 1) || r_stc;
    assign w_idx       = (MSB_FIRST != 0) ? (c_BC_LAST - r_bc) : r_bc;

`ifdef UART_RX_MAJORITY_EN
    logic r_smp_a;
    logic r_smp_b;

    // Capture the two earlier votes around mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp_a <= 1'b1;
            r_smp_b <= 1'b1;
        end else if (w_tick) begin
            if (r_sc == c_SW'(c_MID - 1)) r_smp_a <= w_rxs;
            if (r_sc == c_SW'(c_MID))     r_smp_b <= w_rxs;
        end
    end

    assign w_bit = (r_smp_a & r_smp_b) | (r_smp_a & w_rxs) | (r_smp_b & w_rxs);
`else
    assign w_bit = w_rxs;
`endif

    // Two-flop synchroniser on the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], rx};
    end

    // Free-running prescaler producing the oversample tick.
    always_ff @(posedge clk) begin
        if (rst)         r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next-state logic; every transition is qualified by a tick.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_tick && !w_rxs) w_state_nxt = c_START;
            c_START: begin
                if (w_at_dec && w_bit)  w_state_nxt = c_IDLE;
                else if (w_at_last)     w_state_nxt = c_DATA;
            end
            c_DATA:  if (w_at_last && w_last_bit)
                         w_state_nxt = (PARITY != 0) ? c_PAR : c_STOP;
            c_PAR:   if (w_at_last) w_state_nxt = c_STOP;
            // Leave at mid of the last stop bit so a back-to-back start is caught.
            c_STOP:  if (w_at_dec && w_last_stop) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // FSM outputs: busy flag and frame-completion strobe.
    always_comb begin
        w_busy     = (r_state != c_IDLE);
        w_complete = (r_state == c_STOP) && w_at_dec && w_last_stop;
    end

    // Bit-timing counters: sample counter, data bit counter, stop bit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sc  <= '0;
            r_bc  <= '0;
            r_stc <= 1'b0;
        end else begin
            if (w_tick) begin
                if (r_state == c_IDLE || w_state_nxt != r_state || r_sc == c_SC_LAST)
                    r_sc <= '0;
                else
                    r_sc <= r_sc + 1'b1;
            end
            if (r_state == c_START)
                r_bc <= '0;
            else if (r_state == c_DATA && w_at_last && !w_last_bit)
                r_bc <= r_bc + 1'b1;
            if (r_state != c_STOP)
                r_stc <= 1'b0;
            else if (w_at_last)
                r_stc <= 1'b1;
        end
    end

    // Assemble the word and accumulate parity/framing status for this frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word     <= '0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
        end else begin
            case (r_state)
                c_START: begin
                    r_perr_acc <= 1'b0;
                    r_ferr_acc <= 1'b0;
                end
                c_DATA:  if (w_at_dec) r_word[w_idx] <= w_bit;
                c_PAR:   if (w_at_dec)
                             r_perr_acc <= ((^r_word) ^ w_bit) != (PARITY == 2);
                c_STOP:  if (w_at_dec && !w_bit) r_ferr_acc <= 1'b1;
                default: ;
            endcase
        end
    end

    // Output holding register: load on completion unless the old word is
    // still unaccepted, in which case the new frame is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (w_complete) begin
                if (!r_valid || bus.rx_ready) begin
                    r_data  <= r_word;
                    r_perr  <= r_perr_acc;
                    r_ferr  <= r_ferr_acc | !w_bit;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr   <= 1'b1;
                end
            end else if (r_valid && bus.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.rx_data       = r_data;
    assign bus.rx_valid      = r_valid;
    assign bus.rx_parity_err = r_perr;
    assign bus.rx_frame_err  = r_ferr;
    assign bus.rx_overrun    = r_ovr;
    assign bus.rx_busy       = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_pro.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_pro
//  Purpose  : Self-checking bench for uart_rx_pro: four receivers
//             (MSB-first, LSB-first, even parity, odd parity) fed with
//             directed frames and compared against a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_pro;
    localparam int c_OS  = 16;
    localparam int c_MID = c_OS / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int c_DLY = 1;
`else
    localparam int c_DLY = 0;
`endif

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic rx_a    = 1'b1;
    logic rx_p    = 1'b1;
    logic a_ready = 1'b1;

    always #5 clk = ~clk;

    uart_rx_pro_if #(.WORD_SIZE(8)) if_a ();
    uart_rx_pro_if #(.WORD_SIZE(8)) if_b ();
    uart_rx_pro_if #(.WORD_SIZE(8)) if_c ();
    uart_rx_pro_if #(.WORD_SIZE(8)) if_d ();

    assign if_a.rx_ready = a_ready;
    assign if_b.rx_ready = 1'b1;
    assign if_c.rx_ready = 1'b1;
    assign if_d.rx_ready = 1'b1;

    uart_rx_pro #(.CLOCK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(c_OS),
                  .WORD_SIZE(8), .MSB_FIRST(1), .PARITY(0), .STOP_BITS(1))
        dut_a (.clk(clk), .rst(rst), .rx(rx_a), .bus(if_a));
    uart_rx_pro #(.CLOCK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(c_OS),
                  .WORD_SIZE(8), .MSB_FIRST(0), .PARITY(0), .STOP_BITS(1))
        dut_b (.clk(clk), .rst(rst), .rx(rx_a), .bus(if_b));
    uart_rx_pro #(.CLOCK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(c_OS),
                  .WORD_SIZE(8), .MSB_FIRST(1), .PARITY(1), .STOP_BITS(1))
        dut_c (.clk(clk), .rst(rst), .rx(rx_p), .bus(if_c));
    uart_rx_pro #(.CLOCK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(c_OS),
                  .WORD_SIZE(8), .MSB_FIRST(1), .PARITY(2), .STOP_BITS(1))
        dut_d (.clk(clk), .rst(rst), .rx(rx_p), .bus(if_d));

    logic [3:0] d_valid, d_perr, d_ferr, d_ovr, d_busy;
    logic [7:0] d_data [4];
    assign d_valid = {if_d.rx_valid, if_c.rx_valid, if_b.rx_valid, if_a.rx_valid};
    assign d_perr  = {if_d.rx_parity_err, if_c.rx_parity_err, if_b.rx_parity_err, if_a.rx_parity_err};
    assign d_ferr  = {if_d.rx_frame_err, if_c.rx_frame_err, if_b.rx_frame_err, if_a.rx_frame_err};
    assign d_ovr   = {if_d.rx_overrun, if_c.rx_overrun, if_b.rx_overrun, if_a.rx_overrun};
    assign d_busy  = {if_d.rx_busy, if_c.rx_busy, if_b.rx_busy, if_a.rx_busy};
    assign d_data[0] = if_a.rx_data;
    assign d_data[1] = if_b.rx_data;
    assign d_data[2] = if_c.rx_data;
    assign d_data[3] = if_d.rx_data;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef struct packed {
        int unsigned edge_n;
        int          dut;
        logic [7:0]  data;
        logic        perr;
        logic        ferr;
    } exp_t;

    exp_t        q[$];
    logic [3:0]  m_valid = '0, m_perr = '0, m_ferr = '0, m_ovr = '0;
    logic [7:0]  m_data [4];
    int unsigned ecnt = 0;
    logic        rst_e = 1'b0;
    logic [3:0]  rdy_e = '1;
    logic        chk_on = 1'b0;
    int          ovr_cnt = 0;
    int          hit;
    logic        acc;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = v[7-k];
        return r;
    endfunction

    function automatic int par_of(input int d);
        return (d == 2) ? 1 : (d == 3) ? 2 : 0;
    endfunction

    always @(posedge clk) begin
        ecnt  <= ecnt + 1;
        rst_e <= rst;
        rdy_e <= {3'b111, a_ready};
    end

    // Advance the model after each edge and compare every DUT output.
    always @(negedge clk) begin
        if (rst_e) begin
            q.delete();
            m_valid = '0; m_perr = '0; m_ferr = '0; m_ovr = '0;
            for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
            chk_on = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                acc = m_valid[i] && rdy_e[i];
                hit = -1;
                foreach (q[k]) if (q[k].edge_n == ecnt && q[k].dut == i) hit = k;
                m_ovr[i] = 1'b0;
                if (hit >= 0) begin
                    if (!m_valid[i] || acc) begin
                        m_valid[i] = 1'b1;
                        m_data[i]  = q[hit].data;
                        m_perr[i]  = q[hit].perr;
                        m_ferr[i]  = q[hit].ferr;
                    end else begin
                        m_ovr[i] = 1'b1;
                    end
                    q.delete(hit);
                end else if (acc) begin
                    m_valid[i] = 1'b0;
                end
            end
        end
        if (chk_on) begin
            if (d_ovr[0] === 1'b1) ovr_cnt++;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("dut%0d valid", i), 16'(d_valid[i]), 16'(m_valid[i]));
                chk($sformatf("dut%0d data", i),  16'(d_data[i]),  16'(m_data[i]));
                chk($sformatf("dut%0d perr", i),  16'(d_perr[i]),  16'(m_perr[i]));
                chk($sformatf("dut%0d ferr", i),  16'(d_ferr[i]),  16'(m_ferr[i]));
                chk($sformatf("dut%0d ovr", i),   16'(d_ovr[i]),   16'(m_ovr[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame (word sent MSB first on the line); ln 0 feeds dut a/b,
    // ln 1 feeds the parity receivers. cut>0 aborts driving after cut cycles.
    task automatic send(input int ln, input logic [7:0] word, input logic par,
                        input logic stop, input int gap, input int glitch, input int cut);
        logic [10:0] bits;
        int          nb;
        int          ncyc;
        int unsigned t0;
        exp_t        e;
        logic        v;
        bits    = '1;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = word[7-k];
        if (ln == 1) begin
            bits[9]  = par;
            bits[10] = stop;
            nb = 11;
        end else begin
            bits[9] = stop;
            nb = 10;
        end
        t0 = ecnt;
        if (cut == 0) begin
            for (int d = 2 * ln; d < 2 * ln + 2; d++) begin
                e.edge_n = t0 + 3 + c_OS * (9 + ln) + c_MID + 1 + c_DLY;
                e.dut    = d;
                e.data   = (d == 1) ? rev8(word) : word;
                e.perr   = (par_of(d) == 0) ? 1'b0 : (((^word) ^ par) != (par_of(d) == 2));
                e.ferr   = !stop;
                q.push_back(e);
            end
        end
        ncyc = (cut > 0) ? cut : nb * c_OS;
        for (int c = 0; c < ncyc; c++) begin
            v = bits[c / c_OS] ^ (c == glitch);
            if (ln == 0) rx_a = v; else rx_p = v;
            step();
        end
        if (ln == 0) rx_a = 1'b1; else rx_p = 1'b1;
        repeat (gap) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int ovr_base;
        repeat (3) step();
        rst = 1'b0;
        chk("reset valid", 16'(d_valid), 16'h0);
        chk("reset busy",  16'(d_busy),  16'h0);
        chk("reset data a", 16'(d_data[0]), 16'h0);
        step();

        // Basic frame, MSB-first and LSB-first (palindrome)
        send(0, 8'hA5, 1'b0, 1'b1, 4, -1, 0);
        chk("A5 msb data", 16'(d_data[0]), 16'hA5);
        chk("A5 lsb data", 16'(d_data[1]), 16'hA5);
        chk("A5 ferr", 16'(d_ferr[0]), 16'h0);
        send(0, 8'hC0, 1'b0, 1'b1, 4, -1, 0);
        chk("C0 lsb data", 16'(d_data[1]), 16'h03);
        chk("C0 msb data", 16'(d_data[0]), 16'hC0);

        // Parity: 0x0F has an even number of ones
        send(1, 8'h0F, 1'b1, 1'b1, 4, -1, 0);
        chk("even par1 perr", 16'(d_perr[2]), 16'h1);
        chk("even par1 data", 16'(d_data[2]), 16'h0F);
        chk("odd par1 perr",  16'(d_perr[3]), 16'h0);
        send(1, 8'h0F, 1'b0, 1'b1, 4, -1, 0);
        chk("even par0 perr", 16'(d_perr[2]), 16'h0);
        chk("odd par0 perr",  16'(d_perr[3]), 16'h1);

        // Framing error, then a clean frame
        send(0, 8'h3C, 1'b0, 1'b0, 20, -1, 0);
        chk("ferr data", 16'(d_data[0]), 16'h3C);
        chk("ferr flag", 16'(d_ferr[0]), 16'h1);
        send(0, 8'h5A, 1'b0, 1'b1, 4, -1, 0);
        chk("after ferr data", 16'(d_data[0]), 16'h5A);
        chk("after ferr flag", 16'(d_ferr[0]), 16'h0);

        // Overrun with the consumer stalled
        a_ready  = 1'b0;
        ovr_base = ovr_cnt;
        send(0, 8'h11, 1'b0, 1'b1, 0, -1, 0);
        send(0, 8'h22, 1'b0, 1'b1, 4, -1, 0);
        chk("overrun held data", 16'(d_data[0]), 16'h11);
        chk("overrun held valid", 16'(d_valid[0]), 16'h1);
        chk("overrun pulses", 16'(ovr_cnt - ovr_base), 16'h1);
        a_ready = 1'b1;
        step();
        chk("accept drops valid", 16'(d_valid[0]), 16'h0);
        repeat (4) step();

        // False start
        rx_a = 1'b0;
        repeat (4) step();
        rx_a = 1'b1;
        step();
        chk("false start busy", 16'(d_busy[0]), 16'h1);
        repeat (9) step();
        chk("false start idle", 16'(d_busy[1:0]), 16'h0);
        repeat (4) step();

`ifdef UART_RX_MAJORITY_EN
        // One-cycle high glitch at mid of data bit 3 (a low bit) is outvoted
        send(0, 8'hEF, 1'b0, 1'b1, 4, 4 * c_OS + 9, 0);
        chk("majority glitch data", 16'(d_data[0]), 16'hEF);
`endif

        // Reset mid-frame while a word is held
        a_ready = 1'b0;
        send(0, 8'h99, 1'b0, 1'b1, 4, -1, 0);
        chk("pre-reset valid", 16'(d_valid[0]), 16'h1);
        send(0, 8'h55, 1'b0, 1'b1, 0, -1, 60);
        chk("mid-frame busy", 16'(d_busy[0]), 16'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst valid", 16'(d_valid), 16'h0);
        chk("rst busy",  16'(d_busy),  16'h0);
        chk("rst data",  16'(d_data[0]), 16'h0);
        chk("rst flags", 16'({d_perr, d_ferr, d_ovr}), 16'h0);
        a_ready = 1'b1;
        repeat (4) step();
        send(0, 8'hC3, 1'b0, 1'b1, 4, -1, 0);
        chk("post-reset data", 16'(d_data[0]), 16'hC3);
        chk("post-reset lsb data", 16'(d_data[1]), 16'hC3);

        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_pro.md
Name: uart_rx_pro

Overview:
- Parametrised next-generation UART receiver: configurable word size, bit order, parity, stop-bit count and oversampling.
- Adds mid-bit sampling on an oversample tick, false-start rejection, parity/framing/overrun detection and a valid/ready output handshake.
- Sits between the rx pin and the UART controller; replaces the single-pulse "data available" interface with a held-until-accepted one.

Parameters:
- CLOCK_FREQ, 100_000_000, system clock in Hz.
- BAUD_RATE, 115_200, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit; even, >=8.
- WORD_SIZE, 8, data bits per frame, 5..9.
- MSB_FIRST, 1, 1: first received data bit lands in rx_data[WORD_SIZE-1]; 0: lands in rx_data[0].
- PARITY, 0, 0 none, 1 even, 2 odd.
- STOP_BITS, 1, 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line, idle high.
- rx_data  out  WORD_SIZE  received word, stable while rx_valid=1.
- rx_valid  out  1  word available; held until accepted.
- rx_ready  in  1  consumer accepts when rx_valid&&rx_ready at a posedge.
- rx_parity_err  out  1  parity mismatch for the word on rx_data; 0 when PARITY=0.
- rx_frame_err  out  1  a stop bit sampled low for the word on rx_data.
- rx_overrun  out  1  one-cycle pulse: a frame completed while rx_valid=1 and not accepted.
- rx_busy  out  1  1 in any state except IDLE.

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all counters 0; synchroniser flops 1; rx_data=0, rx_valid=0, both err=0, rx_overrun=0, rx_busy=0. Reset mid-frame aborts the frame silently.
- Input: 2-flop synchroniser on rx, giving 2-cycle latency. All sampling uses the synchronised value rxs.
- Tick: DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE), integer with a minimum of 1. Prescaler counts 0..DIV-1 and free-runs; tick=1 when prescaler==DIV-1.
- Sample counter sc counts 0..OVERSAMPLE-1 on ticks. MID = OVERSAMPLE/2-1.
- States: IDLE, START, DATA, PARITY, STOP. All transitions occur on tick cycles only.
  - IDLE: rxs==0 on a tick -> START, sc=0.
  - START: at sc==MID, rxs==1 -> IDLE (false start, no output). At sc==OVERSAMPLE-1 -> DATA, sc=0, bit counter=0.
  - DATA: at sc==MID, sample the bit into its position per MSB_FIRST. At sc==OVERSAMPLE-1, bit counter==WORD_SIZE-1 -> PARITY if PARITY!=0, else STOP; otherwise increment the bit counter.
  - PARITY: at sc==MID, compute err = (^data ^ rxs) != (PARITY==2). At end of bit -> STOP.
  - STOP: at sc==MID of each stop bit, a low sample sets frame_err. At MID of the last stop bit, complete the frame and -> IDLE immediately. The remaining half-bit is not waited out, so a start bit directly following the stop bit is caught.
- Completion:
  - If rx_valid==0, or rx_valid&&rx_ready in the same cycle: load rx_data and both err flags; rx_valid=1.
  - Else: drop the new frame, keep the old word and flags, pulse rx_overrun for 1 cycle.
- Accept (rx_valid&&rx_ready, no simultaneous completion): rx_valid=0 next cycle. rx_data and the flags keep their last value.
- rx_valid is never deasserted without acceptance or reset.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value (start check, data, parity, stop) is the 2-of-3 majority of rxs sampled at sc==MID-1, MID, MID+1. Decisions are still taken at MID+1 instead of MID. False-start rejection uses the majority value.
- Undefined: single sample at sc==MID, as above.

Test Plan:
Common setup: CLOCK_FREQ=16_000_000, BAUD_RATE=1_000_000, OVERSAMPLE=16 (DIV=1), defaults otherwise.
- Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop), rx_ready=1 -> rx_valid pulses 1 cycle, rx_data=0xA5, no errors; with MSB_FIRST=0 the same line bits give 0xA5 (palindrome check) and line bits 1,1,0,0,0,0,0,0 give 0x03.
- PARITY=1, frame 0x0F with parity bit 1 -> rx_data=0x0F, rx_parity_err=1; parity bit 0 -> rx_parity_err=0. PARITY=2, 0x0F with parity bit 1 -> rx_parity_err=0.
- Stop bit driven 0 for frame 0x3C -> rx_data=0x3C, rx_frame_err=1, rx_valid=1. Next frame is still received correctly.
- rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, rx_overrun pulses once at the second completion. Raise rx_ready -> rx_valid falls the next cycle.
- rx low for 4 cycles, then high -> no rx_valid, rx_busy returns 0 by sc==MID+1. With UART_RX_MAJORITY_EN, a 1-cycle high glitch at MID of data bit 3 of 0xFF with bit 3 low -> rx_data=0xEF (MSB_FIRST).
- rst asserted mid-DATA of frame 0x55 -> all outputs 0 next cycle. A following frame 0xC3 is received correctly.
